// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: reset vector, FSM encoding, NOP word.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/inst_skid_buf.sv
// One-entry holding slot for a returned instruction that arrives while the stage output is stalled.
module inst_skid_buf #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [PC_W-1:0] load_pc,
    input  logic [31:0]     load_inst,
    output logic            valid,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     inst
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, registered IF/ID output with skid slot,
// branch redirect with late-response discard, and misaligned-PC address-error reporting.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(fetch_stage_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_if_id,
    input  logic            flush,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            inst_req,
    output logic [PC_W-1:0] inst_addr,
    input  logic            inst_addr_ok,
    input  logic            inst_data_ok,
    input  logic [31:0]     inst_rdata,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_inst,
    output logic            if_adel,
    output state_t          fsm_state
);

    // Handshakes: a request is accepted on a cycle with inst_req && inst_addr_ok; the stage output
    // is consumed on a cycle with if_valid && !stall_if_id and is held unchanged otherwise.
    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc_reg, pc_nxt;
    logic              discard, discard_nxt;
    logic              err_done, err_done_nxt;
    logic              skid_valid;
    logic [PC_W-1:0]   skid_pc;
    logic [31:0]       skid_inst;
    logic              fire, accept, out_free, refill, to_out, to_skid, err_load;

    assign inst_req  = rst_n && (state == S_REQ) && !skid_valid && (pc_reg[1:0] == 2'b00);
    assign inst_addr = pc_reg;
    assign fsm_state = state;

    assign fire     = inst_req && inst_addr_ok;
    assign accept   = (state == S_WAIT) && inst_data_ok && !discard && !flush;
    assign out_free = !if_valid || !stall_if_id;
    assign refill   = out_free && skid_valid;
    assign to_out   = accept && out_free && !skid_valid;
    assign to_skid  = accept && !to_out;
    assign err_load = (state == S_ERR) && !err_done && out_free && !skid_valid;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_reg;
        discard_nxt  = discard;
        err_done_nxt = err_done;
        unique case (state)
            S_REQ: begin
                if (pc_reg[1:0] != 2'b00) state_nxt = S_ERR;
                else if (fire)            state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_nxt   = S_REQ;
                    discard_nxt = 1'b0;
                    if (accept) pc_nxt = pc_reg + PC_W'(4);
                end
            end
            S_ERR: begin
                if (err_load) err_done_nxt = 1'b1;
            end
            default: state_nxt = S_REQ;
        endcase
        // A redirect leaves a request in flight whenever memory has taken it but not answered yet.
        if (flush) begin
            pc_nxt       = redirect_pc;
            err_done_nxt = 1'b0;
            if (fire || (state == S_WAIT && !inst_data_ok)) begin
                state_nxt   = S_WAIT;
                discard_nxt = 1'b1;
            end else begin
                state_nxt   = S_REQ;
                discard_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_REQ;
            pc_reg   <= RESET_PC;
            discard  <= 1'b0;
            err_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_reg   <= pc_nxt;
            discard  <= discard_nxt;
            err_done <= err_done_nxt;
        end
    end

    // Skid contents always predate new return data, so they refill the output first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_adel  <= 1'b0;
            if_pc    <= '0;
            if_inst  <= '0;
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (refill) begin
            if_valid <= 1'b1;
            if_adel  <= 1'b0;
            if_pc    <= skid_pc;
            if_inst  <= skid_inst;
        end else if (to_out) begin
            if_valid <= 1'b1;
            if_adel  <= 1'b0;
            if_pc    <= pc_reg;
            if_inst  <= inst_rdata;
        end else if (err_load) begin
            if_valid <= 1'b1;
            if_adel  <= 1'b1;
            if_pc    <= pc_reg;
            if_inst  <= NOP;
        end else if (if_valid && !stall_if_id) begin
            if_valid <= 1'b0;
        end
    end

    inst_skid_buf #(
        .PC_W (PC_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (to_skid),
        .unload    (refill),
        .clear     (flush),
        .load_pc   (pc_reg),
        .load_inst (inst_rdata),
        .valid     (skid_valid),
        .pc        (skid_pc),
        .inst      (skid_inst)
    );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter PC_W, default 32, SHALL be the address/PC width.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 stall_if_id  in  1  SHALL mean the IF/ID consumer cannot accept; hold the presented instruction.
REQ-006 flush  in  1  SHALL mean a taken branch/jump redirect; one-cycle pulse.
REQ-007 redirect_pc  in  32  SHALL be the target PC, sampled when flush=1.
REQ-008 inst_req  out  1  SHALL request an instruction-memory fetch.
REQ-009 inst_addr  out  32  SHALL be the fetch address, equal to the internal pc_reg.
REQ-010 inst_addr_ok  in  1  SHALL mean memory accepted the request this cycle.
REQ-011 inst_data_ok  in  1  SHALL mean inst_rdata is valid this cycle.
REQ-012 inst_rdata  in  32  SHALL be the returned instruction word.
REQ-013 if_valid / if_pc / if_inst / if_adel  out  1/32/32/1  SHALL be the registered stage output: valid, PC, instruction, address-error flag.

Function
REQ-014 FSM states SHALL be REQ (request pending), WAIT (one request outstanding) and ERR (misaligned PC).
REQ-015 inst_req SHALL be 1 only in REQ with the skid buffer empty and pc_reg[1:0]==0.
REQ-016 When inst_req && inst_addr_ok, the FSM SHALL go REQ->WAIT; at most one request SHALL be outstanding.
REQ-017 In WAIT, inst_data_ok with discard=0 SHALL write {pc_reg, inst_rdata} to the output register if it is empty or being consumed, else to the 1-entry skid buffer; pc_reg SHALL advance by 4 and the FSM SHALL go to REQ.
REQ-018 The output is consumed when if_valid && !stall_if_id. A refill from the skid buffer SHALL take priority over new return data. Output latency SHALL be 1 cycle from inst_data_ok to if_valid.
REQ-019 While stall_if_id=1, if_valid/if_pc/if_inst/if_adel SHALL hold unchanged.
REQ-020 flush SHALL override stall. On the next edge: pc_reg <= redirect_pc; if_valid <= 0; skid buffer cleared.
REQ-021 If flush occurs in WAIT, or in REQ with inst_addr_ok=1 that cycle, discard SHALL be set. The next inst_data_ok SHALL be dropped, discard SHALL clear, and the FSM SHALL go to REQ.
REQ-022 flush coincident with inst_data_ok in WAIT SHALL drop that data without setting discard.
REQ-023 If pc_reg[1:0]!=0 in REQ, the FSM SHALL enter ERR. It SHALL present if_valid=1, if_adel=1, if_inst=0, if_pc=pc_reg once (held under stall), then stay idle with if_valid=0 until flush.
REQ-024 pc_reg+4 SHALL wrap modulo 2^32 with no flag.

Reset
REQ-025 rst_n=0 SHALL immediately force pc_reg=RESET_PC, state=REQ, discard=0, skid empty, if_valid=0, if_adel=0, if_pc=0, if_inst=0, and inst_req=0.
REQ-026 Reset asserted mid-transaction SHALL abandon any outstanding request. inst_data_ok arriving with state=REQ SHALL be ignored.
REQ-027 The first inst_req SHALL assert in the first cycle after rst_n deasserts.

Structure
REQ-028 The shared package SHALL hold RESET_PC, the FSM state encoding, and the NOP constant (32'h0).
REQ-029 The skid buffer SHALL be a sub-module, inst_skid_buf (valid/pc/inst, load/unload/clear).

Verification
REQ-030 Scenario: reset release, addr_ok and data_ok each 1 cycle after request, rdata 32'h2408_0001 -> if_pc=BFC0_0000, if_inst=2408_0001; next inst_addr=BFC0_0004.
REQ-031 Scenario: stall_if_id held 5 cycles while two words return -> first word held on outputs, second in skid; after release both appear on consecutive cycles with no loss or duplication.
REQ-032 Scenario: flush with redirect_pc=8000_0100 while in WAIT -> the late data_ok word never appears; next inst_addr=8000_0100.
REQ-033 Scenario: flush coincident with inst_addr_ok -> discard set, one response dropped, then fetch from the target.
REQ-034 Scenario: flush with redirect_pc=8000_0102 -> no inst_req; one output with if_adel=1, if_pc=8000_0102, if_inst=0.
REQ-035 Scenario: rst_n pulsed low in WAIT, then a stale data_ok -> outputs stay invalid; fetch restarts at BFC0_0000.
